// File: rtl/demux1to5_stream_pkg.sv
// Shared constants and helpers for the 1-to-5 stream demultiplexer.
package demux1to5_stream_pkg;
    localparam int NCH       = 5;
    localparam int SEL_W     = 3;
    localparam int SEL_CODES = 1 << SEL_W;
    localparam logic [SEL_W-1:0] SEL_MAX = 3'd4;

    typedef logic [SEL_W-1:0] sel_t;

    // A select addresses a real channel only up to SEL_MAX.
    function automatic logic sel_legal(input sel_t sel);
        return sel <= SEL_MAX;
    endfunction
endpackage

// File: rtl/demux1to5_stream_if.sv
// Input stream plus the five per-channel output streams of the demux.
interface demux1to5_stream_if
    import demux1to5_stream_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]     in_data;
    logic [SEL_W-1:0]     in_sel;
    logic                 in_valid;
    logic                 in_ready;
    logic [NCH*WIDTH-1:0] out_data;
    logic [NCH-1:0]       out_valid;
    logic [NCH-1:0]       out_ready;

    // Producer / consumer side.
    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    // Demux side.
    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/demux1to5_stream_demux_slot.sv
// One-entry holding register for a single output channel. Load wins over
// drain so a drain-and-load edge keeps the slot full with the new word.
module demux_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             free
);
    // Slot can take a word if empty or being drained this edge.
    assign free = ~valid | ready;

    // Hold register; data is only rewritten on load and keeps its value when drained.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= din;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/demux1to5_stream.sv
// Registered 1-to-5 stream demultiplexer: select decode, in_ready mux,
// five holding slots and the illegal-select error/drop counter.
module demux1to5_stream
    import demux1to5_stream_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    demux1to5_stream_if.slave     bus,
    output logic                  err_sel,
    output logic [DROP_CNT_W-1:0] drop_cnt
);
    logic [NCH-1:0]            slot_free;
    logic [NCH-1:0]            slot_vld;
    logic [NCH-1:0]            slot_load;
    logic [NCH-1:0][WIDTH-1:0] slot_data;
    logic [SEL_CODES-1:0]      free_map;
    logic                      sel_ok;
    logic                      accept;
    logic                      drop;

    // Illegal codes map to "always free" so they are swallowed without stalling.
    assign free_map     = {{(SEL_CODES-NCH){1'b1}}, slot_free};
    assign sel_ok       = sel_legal(bus.in_sel);
    assign bus.in_ready = rst_n & free_map[bus.in_sel];
    assign accept       = bus.in_valid & bus.in_ready;
    assign drop         = accept & ~sel_ok;

    assign bus.out_valid = slot_vld;
    assign bus.out_data  = slot_data;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign slot_load[k] = accept & (bus.in_sel == SEL_W'(k));

        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (slot_load[k]),
            .din   (bus.in_data),
            .ready (bus.out_ready[k]),
            .valid (slot_vld[k]),
            .data  (slot_data[k]),
            .free  (slot_free[k])
        );
    end

    // One-cycle error pulse and saturating count of dropped words.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_sel  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            err_sel <= drop;
            if (drop && !(&drop_cnt))
                drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
    end
endmodule

// File: doc/demux1to5_stream.md
Name: demux1to5_stream

Overview:
Registered 1-to-5 stream demultiplexer. It is the distribution end of the 5:1 select datapath: one valid/ready input stream carries a 3-bit destination select, and each word is steered to one of five independent output channels. Each channel holds one word until its consumer accepts it. Select codes 5..7 are illegal; those words are discarded, flagged and counted.

Parameters:
WIDTH, 8, data word width in bits
DROP_CNT_W, 8, width of the saturating illegal-select drop counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
in_data  input  WIDTH  input word
in_sel  input  3  destination channel; 0..4 legal, 5..7 illegal
in_valid  input  1  input word present
in_ready  output  1  block accepts input this cycle
out_data  output  5*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
out_valid  output  5  per-channel word held
out_ready  input  5  per-channel consumer accepts
err_sel  output  1  one-cycle pulse: an illegal-select word was dropped
drop_cnt  output  DROP_CNT_W  number of dropped words, saturating

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low on rst_n. While rst_n=0 at a rising edge, the block sets out_valid=0, out_data=0, err_sel=0 and drop_cnt=0. in_ready is forced to 0 while rst_n=0.
- Accept: a word transfers when in_valid & in_ready at a rising edge.
- in_ready is combinational:
  - in_sel in 0..4: in_ready = ~out_valid[in_sel] | out_ready[in_sel].
  - in_sel in 5..7: in_ready = 1.
  - in_ready does not depend on in_valid. It does depend on out_ready, so there is a combinational path from out_ready to in_ready by design.
- Latency: a word accepted at edge N appears on out_data[k] with out_valid[k]=1 after edge N. Output is registered, 1 cycle.
- Channel hold: once out_valid[k]=1, out_data[k] is stable until the edge where out_ready[k]=1.
  - Drain only: out_valid[k] goes to 0 after that edge.
  - out_data[k] keeps its last value when not valid. It is not cleared.
- Simultaneous drain and load on the same channel: out_valid[k] stays 1 and out_data[k] takes the new word. Sustained throughput is 1 word/cycle per channel.
- Channels are independent. A stalled channel blocks input only while in_sel addresses it (head-of-line blocking is accepted). Other channels keep draining.
- Illegal select, word accepted with in_sel>=5:
  - No out_valid changes.
  - err_sel=1 for exactly the cycle after the accept edge.
  - drop_cnt increments by 1 and saturates at all-ones, with no wrap.
  - Back-to-back illegal words give err_sel high on consecutive cycles.
- in_sel and in_data are don't-care when in_valid=0. No state changes and err_sel=0.
- Reset mid-operation: all held words are discarded without handshake, and drop_cnt clears. The first accept is possible on the first edge with rst_n=1.
- No X propagation: out_valid and err_sel are always driven from reset state.

Decomposition:
- Shared package:
  - NCH=5
  - SEL_W=3
  - SEL_MAX=3'd4 (highest legal select)
  - function sel_legal(sel) returning sel<=SEL_MAX
- Sub-module demux_slot, instantiated 5 times: a one-entry holding register with load, valid/ready handshake and drain-and-load in the same cycle. The top level contains select decode, in_ready mux, and the err/drop counter logic.

Test Plan:
1. Reset: drive rst_n=0 for 2 cycles with in_valid=1 and in_sel=2 -> in_ready=0, out_valid=5'b00000, err_sel=0, drop_cnt=0; no word captured.
2. Routing: with all out_ready=1, send 8'hA0..8'hA4 on sel 0..4 on consecutive cycles -> each out_valid[k] pulses one cycle later with out_data[k]=8'hA0+k; in_ready stays 1.
3. Backpressure: out_ready[2]=0; send 8'h11 on sel 2, then 8'h22 on sel 2, then 8'h33 on sel 4 -> 8'h11 held on ch2 and in_ready=0 while 8'h22 is presented; 8'h33 cannot pass until out_ready[2]=1; then 8'h22 replaces 8'h11 on the drain edge and 8'h33 reaches ch4 one cycle later.
4. Throughput: 16 back-to-back words on sel 3 with out_ready[3]=1 -> out_valid[3] high for 16 consecutive cycles, in order, with no bubbles.
5. Illegal select: send in_sel=5, 6, 7 back-to-back -> err_sel high for 3 cycles, drop_cnt=3, no out_valid change. Then force 300 illegal words with DROP_CNT_W=8 -> drop_cnt=8'hFF and stays.
6. Reset mid-operation: hold words on ch0 and ch4 (out_ready=0) with drop_cnt=5, pulse rst_n=0 for 1 cycle -> out_valid=0, drop_cnt=0; the next legal word routes normally.
